// File: rtl/conv_encoder_k7.sv
// Rate-1/2, K=7 convolutional encoder with zero-tail frame termination.
// One info bit in per handshake, one 2-bit code symbol out per handshake.
// out_pair = {c1 (G0), c0 (G1)}, matching the decoder's rx_pair pairing.
//
// state | meaning
// ------+------------------------------------------------------------
// DATA  | accepting info bits; in_ready follows the output load enable
// TAIL  | flushing K-1 zero bits so the trellis ends in state 0
module conv_encoder_k7 #(
    parameter int           K  = 7,
    parameter logic [K-1:0] G0 = 7'o171,
    parameter logic [K-1:0] G1 = 7'o133
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_pair,
    output logic       out_last,
    output logic       out_tail
);

    localparam int TC_W = $clog2(K);

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_TAIL = 1'b1
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [K-2:0]    sr;
    logic [TC_W-1:0] tail_cnt;
    logic [TC_W-1:0] tail_cnt_nxt;
    logic            load;
    logic            shift;
    logic            u;
    logic            sym_last;
    logic            sym_tail;
    logic [K-1:0]    w;
    logic [1:0]      sym;

    // The output register can take a new symbol when empty or being drained.
    assign load = !out_valid || out_ready;

    // Code window: current bit on top, most recent past bit just below it.
    assign w   = {u, sr};
    assign sym = {^(w & G0), ^(w & G1)};

    // Next-state logic and symbol generation for the current cycle.
    always_comb begin
        next_state   = state;
        tail_cnt_nxt = tail_cnt;
        in_ready     = 1'b0;
        shift        = 1'b0;
        u            = 1'b0;
        sym_last     = 1'b0;
        sym_tail     = 1'b0;
        case (state)
            ST_DATA: begin
                in_ready = load;
                if (in_valid && load) begin
                    shift = 1'b1;
                    u     = in_bit;
                    if (in_last) begin
                        next_state   = ST_TAIL;
                        tail_cnt_nxt = '0;
                    end
                end
            end
            ST_TAIL: begin
                if (load) begin
                    shift        = 1'b1;
                    sym_tail     = 1'b1;
                    tail_cnt_nxt = tail_cnt + 1'b1;
                    // Final tail symbol: shift register is all zero after it.
                    if (tail_cnt == TC_W'(K - 2)) begin
                        sym_last     = 1'b1;
                        next_state   = ST_DATA;
                        tail_cnt_nxt = '0;
                    end
                end
            end
            default: begin
                next_state   = ST_DATA;
                tail_cnt_nxt = '0;
            end
        endcase
    end

    // FSM state, tail counter and encoder shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_DATA;
            tail_cnt <= '0;
            sr       <= '0;
        end else begin
            state    <= next_state;
            tail_cnt <= tail_cnt_nxt;
            if (shift) begin
                sr <= w[K-1:1];
            end
        end
    end

    // Single output register; holds its contents while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pair  <= 2'b00;
            out_last  <= 1'b0;
            out_tail  <= 1'b0;
        end else if (load) begin
            out_valid <= shift;
            if (shift) begin
                out_pair <= sym;
                out_last <= sym_last;
                out_tail <= sym_tail;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_k7.sv
// Testbench for conv_encoder_k7: scenario tasks plus a symbol scoreboard
// fed by a convolution-sum reference model.
module tb_conv_encoder_k7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_bit = 1'b0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [1:0] out_pair;
    logic       out_last;
    logic       out_tail;

    int total = 0;
    int bad   = 0;

    // expected entries: {pair[1:0], last, tail}
    logic [3:0] ref_q[$];
    logic       frame_bits[64];
    int         ready_mode = 0;
    int         ready_phase = 0;
    bit         ignore_out = 1'b0;
    bit         held_valid = 1'b0;
    logic [3:0] held_val;

    conv_encoder_k7 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pair  (out_pair),
        .out_last  (out_last),
        .out_tail  (out_tail)
    );

    always #5 clk = ~clk;

    // Reference: symbol n is the GF(2) convolution of the zero-padded
    // bit sequence with each generator (generator MSB weights the newest bit).
    function automatic void model_frame(input int len);
        logic [6:0] g0;
        logic [6:0] g1;
        logic       c1;
        logic       c0;
        logic       x;
        g0 = 7'o171;
        g1 = 7'o133;
        for (int n = 0; n < len + 6; n++) begin
            c1 = 1'b0;
            c0 = 1'b0;
            for (int i = 0; i < 7; i++) begin
                x = 1'b0;
                if (n - i >= 0 && n - i < len) x = frame_bits[n - i];
                c1 = c1 ^ (g0[6 - i] & x);
                c0 = c0 ^ (g1[6 - i] & x);
            end
            ref_q.push_back({c1, c0, (n == len + 5), (n >= len)});
        end
    endfunction

    function automatic void push_impulse();
        logic [1:0] imp[7];
        imp = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
        for (int i = 0; i < 7; i++)
            ref_q.push_back({imp[i], (i == 6), (i != 0)});
    endfunction

    // out_ready generator: 0 = always, 1 = pattern 1,0,0,1, 2 = random 70%
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready   = (ready_phase == 0 || ready_phase == 3);
                    ready_phase = (ready_phase + 1) % 4;
                end
                default: out_ready = ($urandom_range(99) < 70);
            endcase
        end
    end

    // Output monitor: stability while stalled and scoreboard on handshake.
    always @(negedge clk) begin
        if (rst) begin
            total++;
            if ({out_valid, out_pair, out_last, out_tail} !== 5'b0) begin
                bad++;
                $display("FAIL reset_outputs: got valid=%0b pair=%b last=%0b tail=%0b, want all 0",
                         out_valid, out_pair, out_last, out_tail);
            end
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                total++;
                if (!out_valid || {out_pair, out_last, out_tail} !== held_val) begin
                    bad++;
                    $display("FAIL stall_hold: got valid=%0b val=%b, want valid=1 val=%b",
                             out_valid, {out_pair, out_last, out_tail}, held_val);
                end
            end
            if (out_valid && out_ready && !ignore_out) begin
                total++;
                if (ref_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_symbol: got val=%b, want no symbol",
                             {out_pair, out_last, out_tail});
                end else if ({out_pair, out_last, out_tail} !== ref_q[0]) begin
                    bad++;
                    $display("FAIL symbol: got pair=%b last=%0b tail=%0b, want pair=%b last=%0b tail=%0b",
                             out_pair, out_last, out_tail, ref_q[0][3:2], ref_q[0][1], ref_q[0][0]);
                    void'(ref_q.pop_front());
                end else begin
                    void'(ref_q.pop_front());
                end
            end
            held_valid = out_valid && !out_ready;
            held_val   = {out_pair, out_last, out_tail};
        end
    end

    // Entered and left at posedge+1. Holds in_valid until the handshake.
    task automatic send_bit(input logic b, input logic l, input int vprob);
        int guard;
        while ($urandom_range(99) >= vprob) begin
            in_valid = 1'b0;
            in_bit   = 1'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = l;
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got in_ready=0 for 200 cycles, want 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int len, input int vprob);
        for (int i = 0; i < len; i++)
            send_bit(frame_bits[i], (i == len - 1), vprob);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (ref_q.size() != 0 && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        total++;
        if (ref_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d symbols outstanding, want 0", ref_q.size());
            ref_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_after_reset: got out_valid=%0b in_ready=%0b, want 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_impulse();
        ready_mode = 0;
        push_impulse();
        frame_bits[0] = 1'b1;
        send_frame(1, 100);
        drain();
    endtask

    task automatic test_zero_frame();
        ready_mode = 0;
        for (int i = 0; i < 8; i++) frame_bits[i] = 1'b0;
        for (int i = 0; i < 14; i++) ref_q.push_back({2'b00, (i == 13), (i >= 8)});
        send_frame(8, 100);
        // A following impulse only reproduces the reference if sr returned to 0.
        push_impulse();
        frame_bits[0] = 1'b1;
        send_frame(1, 100);
        drain();
    endtask

    task automatic test_backpressure();
        ready_mode  = 1;
        ready_phase = 0;
        frame_bits[0] = 1'b1;
        frame_bits[1] = 1'b0;
        frame_bits[2] = 1'b1;
        frame_bits[3] = 1'b1;
        model_frame(4);
        send_frame(4, 100);
        drain();
        ready_mode = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        ready_mode = 0;
        push_impulse();
        push_impulse();
        in_valid = 1'b1;
        in_bit   = 1'b1;
        in_last  = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            total++;
            if (in_ready !== (c == 0 || c == 7)) begin
                bad++;
                $display("FAIL b2b_in_ready: cycle %0d got %0b, want %0b",
                         c, in_ready, (c == 0 || c == 7));
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid_frame();
        ready_mode = 0;
        ignore_out = 1'b1;
        send_bit(1'b1, 1'b0, 100);
        send_bit(1'b1, 1'b0, 100);
        send_bit(1'b0, 1'b0, 100);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        ignore_out = 1'b0;
        push_impulse();
        frame_bits[0] = 1'b1;
        send_frame(1, 100);
        drain();
    endtask

    task automatic test_random();
        int len;
        ready_mode = 2;
        for (int f = 0; f < 200; f++) begin
            len = $urandom_range(64, 1);
            for (int i = 0; i < len; i++) frame_bits[i] = 1'($urandom);
            model_frame(len);
            send_frame(len, 70);
        end
        drain();
        ready_mode = 0;
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_zero_frame();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion by time limit, want completion");
        $fatal(1, "watchdog");
    end

endmodule
